ssd_scan_driver: RTL and testbench
==================================

Name: ssd_scan_driver

Overview:
- Time-multiplexed driver for an N-digit common-anode seven-segment display.
- Latches a packed hex value into a shadow register and scans one digit at a time at a programmable refresh rate.
- Decodes each nibble to active-low segments and drives active-low anode selects.
- Adds optional leading-zero blanking and per-digit enables.
- Sits at the board top level between the debug/status datapath (register file, PC, ALU result taps) and the display pins.

Parameters:
- DIGITS, 4: number of digits scanned; legal range 1..8.
- CLK_DIV, 100000: clk cycles each digit stays lit; legal range >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- value  input  4*DIGITS  packed hex value; nibble i (bits 4i+3:4i) drives digit i, where digit 0 is least significant.
- load  input  1  when 1 at a clk edge, value is copied into the shadow register.
- digit_en  input  DIGITS  per-digit enable; a 0 forces that digit dark.
- blank_lz  input  1  enables leading-zero blanking.
- seg  output  7  active-low segments, bit order g..a (bit 6 = g, bit 0 = a).
- an  output  DIGITS  active-low anode selects; at most one bit is low at any time.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - prescaler = 0, scan index = 0, shadow = 0.
  - seg = 7'b1111111, an = all 1s.
  - Reset asserted mid-scan takes effect immediately, regardless of clk.
- Prescaler:
  - Width is $clog2(CLK_DIV).
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - tick = 1 in the cycle the count equals CLK_DIV-1.
- Scan index:
  - Advances on tick; wraps from DIGITS-1 to 0.
  - With DIGITS = 1 the index stays at 0.
- Shadow register:
  - load = 1 → shadow <= value on that edge.
  - load is independent of tick; if load and tick coincide, both take effect on the same edge.
- Output register (seg, an):
  - Updated every cycle from the current index and shadow.
  - Latency: one cycle from an index change or shadow update to the pins.
  - A load at edge N is visible on seg at edge N+1 if that digit is selected.
- Decode, active-low g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Blanking: the selected digit i is dark (an bit i = 1, seg = 1111111) if either:
  - digit_en[i] = 0, or
  - blank_lz = 1 and i != 0 and nibble i and every nibble above i are zero.
  - Digit 0 is never blanked by leading-zero logic, so an all-zero value shows "0".
- Otherwise an = ~(1 << index) and seg = decode(nibble index).
- Changes to digit_en or blank_lz take effect with the same one-cycle latency and do not disturb the prescaler or the scan index.

Optional Feature:
- Macro: SSD_DP_EN.
- Defined:
  - Adds input dp_in [DIGITS-1:0], latched into the shadow alongside value on load.
  - Adds output dp (1 bit, active-low) = ~dp_in_shadow[index] for a lit digit.
  - dp = 1 when the digit is blanked or during reset.
- Undefined: neither port exists; no decimal-point logic is present.

Test Plan:
- Reset release, DIGITS=4, CLK_DIV=4, digit_en=4'hF, load=0 → first cycle after release: an=1110, seg=1000000; an steps 1110→1101→1011→0111→1110, changing every 4 cycles.
- Load value=16'h12AF with blank_lz=0 → on successive digits seg reads 0001110 (F), 0001000 (A), 0100100 (2), 1111001 (1); first change appears one cycle after load.
- blank_lz=1, value=16'h0030 → digits 3 and 2 show an bit high with seg=1111111; digit 1 shows 0110000; digit 0 shows 1000000. value=16'h0000 → only digit 0 lit, seg=1000000.
- digit_en=4'b1011, value=16'h8888 → while index=2: an=1111, seg=1111111; the other three digits show 0000000.
- Assert rst_n=0 mid-digit (index=2, prescaler=1) → seg and an go all 1s without a clk edge; after release the scan restarts at index 0 with a full CLK_DIV-cycle dwell.
- SSD_DP_EN defined, dp_in=4'b0101 loaded → dp=0 on digits 0 and 2 and dp=1 on digits 1 and 3; with digit_en[2]=0, dp=1 on digit 2.

Source files
------------

// File: rtl/ssd_scan_driver_if.sv
// Display-side bus for ssd_scan_driver: hex value, load strobe, digit
// enables, blanking control and the active-low segment/anode pins.
// Decimal-point signals exist only when SSD_DP_EN is defined.
interface ssd_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic                load;
    logic [DIGITS-1:0]   digit_en;
    logic                blank_lz;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   an;
`ifdef SSD_DP_EN
    logic [DIGITS-1:0]   dp_in;
    logic                dp;

    modport master (output value, load, digit_en, blank_lz, dp_in,
                    input  seg, an, dp);
    modport slave  (input  value, load, digit_en, blank_lz, dp_in,
                    output seg, an, dp);
`else
    modport master (output value, load, digit_en, blank_lz,
                    input  seg, an);
    modport slave  (input  value, load, digit_en, blank_lz,
                    output seg, an);
`endif
endinterface

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed common-anode seven-segment scan driver.
// A shadow register holds the displayed hex value; one digit is lit at a
// time, advancing every CLK_DIV clocks. Outputs are registered (one cycle
// behind the scan index and shadow). Optional decimal point: SSD_DP_EN.
module ssd_scan_driver #(
    parameter int DIGITS  = 4,
    parameter int CLK_DIV = 100000
) (
    input logic              clk,
    input logic              rst_n,
    ssd_scan_driver_if.slave bus
);
    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] INDEX_LAST = IW'(DIGITS - 1);

    logic [PW-1:0]       presc;
    logic                tick;
    logic [IW-1:0]       index;
    logic [4*DIGITS-1:0] shadow;
    logic [DIGITS-1:0]   lz_mask;
    logic [6:0]          seg_next;
    logic [DIGITS-1:0]   an_next;
    logic [6:0]          seg_q;
    logic [DIGITS-1:0]   an_q;
`ifdef SSD_DP_EN
    logic [DIGITS-1:0]   dp_shadow;
    logic                dp_next;
    logic                dp_q;
`endif

    // Hex nibble to active-low segments, bit order g..a.
    function automatic logic [6:0] decode7(input logic [3:0] nib);
        case (nib)
            4'h0: decode7 = 7'b1000000;
            4'h1: decode7 = 7'b1111001;
            4'h2: decode7 = 7'b0100100;
            4'h3: decode7 = 7'b0110000;
            4'h4: decode7 = 7'b0011001;
            4'h5: decode7 = 7'b0010010;
            4'h6: decode7 = 7'b0000010;
            4'h7: decode7 = 7'b1111000;
            4'h8: decode7 = 7'b0000000;
            4'h9: decode7 = 7'b0010000;
            4'hA: decode7 = 7'b0001000;
            4'hB: decode7 = 7'b0000011;
            4'hC: decode7 = 7'b1000110;
            4'hD: decode7 = 7'b0100001;
            4'hE: decode7 = 7'b0000110;
            default: decode7 = 7'b0001110;
        endcase
    endfunction

    assign tick = (presc == PRESC_LAST);

    // Refresh prescaler: counts 0..CLK_DIV-1, tick on the last count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + 1'b1;
    end

    // Scan index: advances on tick, wraps after the last digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index <= '0;
        end else if (tick) begin
            if (index == INDEX_LAST) index <= '0;
            else                     index <= index + 1'b1;
        end
    end

    // Shadow register: captured on load, independent of the scan tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
`ifdef SSD_DP_EN
            dp_shadow <= '0;
`endif
        end else if (bus.load) begin
            shadow <= bus.value;
`ifdef SSD_DP_EN
            dp_shadow <= bus.dp_in;
`endif
        end
    end

    // Leading-zero mask: bit i set when nibble i and all higher nibbles are zero.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run   = zero_run && (shadow[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_run;
        end
    end

    // Select the current digit; dark if disabled or a blanked leading zero.
    always_comb begin
        seg_next = 7'b1111111;
        an_next  = '1;
`ifdef SSD_DP_EN
        dp_next  = 1'b1;
`endif
        for (int i = 0; i < DIGITS; i++) begin
            if (index == IW'(i)) begin
                if (bus.digit_en[i] && !(bus.blank_lz && (i != 0) && lz_mask[i])) begin
                    seg_next   = decode7(shadow[4*i +: 4]);
                    an_next[i] = 1'b0;
`ifdef SSD_DP_EN
                    dp_next    = ~dp_shadow[i];
`endif
                end
            end
        end
    end

    // Output register: pins are dark during and right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= 7'b1111111;
            an_q  <= '1;
`ifdef SSD_DP_EN
            dp_q  <= 1'b1;
`endif
        end else begin
            seg_q <= seg_next;
            an_q  <= an_next;
`ifdef SSD_DP_EN
            dp_q  <= dp_next;
`endif
        end
    end

    assign bus.seg = seg_q;
    assign bus.an  = an_q;
`ifdef SSD_DP_EN
    assign bus.dp  = dp_q;
`endif
endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver (DIGITS=4, CLK_DIV=4).
// Expected outputs come from an arithmetic model: the digit shown after
// edge k is ((k-1)/CLK_DIV) % DIGITS, decoded from the shadow as it stood
// before that edge. Honors SSD_DP_EN when defined.
module tb_ssd_scan_driver;
    localparam int DIGITS  = 4;
    localparam int CLK_DIV = 4;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int checks = 0;
    int errors = 0;

    int          m_edges;
    logic [15:0] m_shadow;
    logic [3:0]  m_dp;

    always #5 clk = ~clk;

    ssd_scan_driver_if #(.DIGITS(DIGITS)) bus ();

    ssd_scan_driver #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check_outputs(input string tag, input logic [6:0] exp_seg,
                                 input logic [3:0] exp_an, input logic exp_dp);
        checks++;
        assert (bus.seg === exp_seg) else begin
            errors++;
            $error("FAIL %s seg: observed %b expected %b", tag, bus.seg, exp_seg);
        end
        checks++;
        assert (bus.an === exp_an) else begin
            errors++;
            $error("FAIL %s an: observed %b expected %b", tag, bus.an, exp_an);
        end
`ifdef SSD_DP_EN
        checks++;
        assert (bus.dp === exp_dp) else begin
            errors++;
            $error("FAIL %s dp: observed %b expected %b", tag, bus.dp, exp_dp);
        end
`endif
    endtask

    task automatic model_expect(output logic [6:0] es, output logic [3:0] ea,
                                output logic ed);
        int   i;
        logic lit;
        i   = (m_edges / CLK_DIV) % DIGITS;
        lit = bus.digit_en[i] &&
              !(bus.blank_lz && (i != 0) && ((m_shadow >> (4 * i)) == 16'h0));
        es  = lit ? SEG_TABLE[(m_shadow >> (4 * i)) & 16'hF] : 7'b1111111;
        ea  = lit ? (4'hF ^ (4'h1 << i)) : 4'hF;
        ed  = lit ? ~m_dp[i] : 1'b1;
    endtask

    task automatic cycle(input string tag);
        logic [6:0] es;
        logic [3:0] ea;
        logic       ed;
        model_expect(es, ea, ed);
        if (bus.load) begin
            m_shadow = bus.value;
`ifdef SSD_DP_EN
            m_dp = bus.dp_in;
`endif
        end
        @(posedge clk);
        #1;
        m_edges++;
        check_outputs(tag, es, ea, ed);
    endtask

    task automatic reset_cycle(input string tag);
        @(posedge clk);
        #1;
        check_outputs(tag, 7'b1111111, 4'hF, 1'b1);
    endtask

    task automatic model_reset();
        m_edges  = 0;
        m_shadow = 16'h0;
        m_dp     = 4'h0;
    endtask

    initial begin
        int guard;
        logic [15:0] rv;

        bus.value    = 16'h0;
        bus.load     = 1'b0;
        bus.digit_en = 4'hF;
        bus.blank_lz = 1'b0;
`ifdef SSD_DP_EN
        bus.dp_in    = 4'h0;
`endif
        model_reset();

        // Reset state
        #1 rst_n = 1'b0;
        #1 check_outputs("reset_async", 7'b1111111, 4'hF, 1'b1);
        repeat (3) reset_cycle("reset_hold");
        rst_n = 1'b1;

        // Idle scan after release: digit 0 shows "0", anodes rotate every 4 clocks
        repeat (20) cycle("scan_idle");

        // Load 12AF (and dp pattern 0101), no blanking
`ifdef SSD_DP_EN
        bus.dp_in = 4'b0101;
`endif
        bus.value = 16'h12AF;
        bus.load  = 1'b1;
        cycle("load_12af");
        bus.load  = 1'b0;
        bus.value = 16'hFFFF;
        repeat (18) cycle("scan_12af");

        // Leading-zero blanking
        bus.blank_lz = 1'b1;
        bus.value    = 16'h0030;
        bus.load     = 1'b1;
        cycle("load_0030");
        bus.load = 1'b0;
        repeat (16) cycle("blank_0030");
        bus.value = 16'h0000;
        bus.load  = 1'b1;
        cycle("load_0000");
        bus.load = 1'b0;
        repeat (16) cycle("blank_0000");

        // Per-digit enable with digit 2 disabled
        bus.blank_lz = 1'b0;
        bus.digit_en = 4'b1011;
        bus.value    = 16'h8888;
        bus.load     = 1'b1;
        cycle("load_8888");
        bus.load = 1'b0;
        repeat (16) cycle("digit_en_1011");
        bus.digit_en = 4'hF;

        // Mid-digit asynchronous reset at index 2, prescaler 1
        guard = 0;
        while (!(((m_edges / CLK_DIV) % DIGITS) == 2 && (m_edges % CLK_DIV) == 1)
               && guard < 64) begin
            cycle("seek_idx2");
            guard++;
        end
        checks++;
        assert (guard < 64) else begin
            errors++;
            $error("FAIL seek_idx2 cycles: observed %0d expected below 64", guard);
        end
        #2 rst_n = 1'b0;
        #1 check_outputs("reset_mid", 7'b1111111, 4'hF, 1'b1);
        model_reset();
        repeat (2) reset_cycle("reset_mid_hold");
        rst_n = 1'b1;
        repeat (20) cycle("restart");

        // Randomized traffic, nibbles biased toward zero to hit blanking
        repeat (400) begin
            rv = 16'h0;
            for (int k = 0; k < 4; k++)
                if ($urandom_range(1) == 1) rv[4*k +: 4] = 4'($urandom_range(15));
            bus.value = rv;
            bus.load  = ($urandom_range(3) == 0);
`ifdef SSD_DP_EN
            bus.dp_in = 4'($urandom_range(15));
`endif
            if ($urandom_range(7) == 0) bus.digit_en = 4'($urandom_range(15));
            if ($urandom_range(7) == 0) bus.blank_lz = 1'($urandom_range(1));
            cycle("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
